contador_hora: RTL and testbench

CONTADOR_HORA -- requirements
Module: contador_hora

---
 rtl/contador_hora_pkg.sv | 32 +++
 rtl/divisor_tick.sv | 28 ++
 rtl/contador_hora.sv | 109 ++++++++++
 tb/tb_contador_hora.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/contador_hora_pkg.sv
// Shared definitions for the time-of-day counter: field limits, field
// selector encodings and controller state encoding.
package contador_hora_pkg;

    localparam int CAMPO_W = 7;

    localparam logic [CAMPO_W-1:0] MAX_SEG  = 7'd59;
    localparam logic [CAMPO_W-1:0] MAX_MIN  = 7'd59;
    localparam logic [CAMPO_W-1:0] MAX_HORA = 7'd23;

    typedef enum logic [1:0] {
        SEL_SEG     = 2'b00,
        SEL_MIN     = 2'b01,
        SEL_HORA    = 2'b10,
        SEL_NINGUNO = 2'b11
    } sel_campo_e;

    typedef enum logic {
        CUENTA   = 1'b0,
        PROGRAMA = 1'b1
    } estado_e;

    function automatic logic [CAMPO_W-1:0] max_campo(input sel_campo_e sel);
        case (sel)
            SEL_SEG:  max_campo = MAX_SEG;
            SEL_MIN:  max_campo = MAX_MIN;
            SEL_HORA: max_campo = MAX_HORA;
            default:  max_campo = '0;
        endcase
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// One-second prescaler: counts enabled cycles 0..PRESCALE-1 and flags the
// last one; clr forces the count back to zero.
module divisor_tick #(
    parameter int PRESCALE = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(PRESCALE);
    localparam logic [W-1:0] ULTIMO = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == ULTIMO) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == ULTIMO);

endmodule

// File: rtl/contador_hora.sv
// Binary hh:mm:ss time-of-day counter with a programming mode for
// stepping or loading one field at a time.
module contador_hora
    import contador_hora_pkg::*;
#(
    parameter int PRESCALE = 100000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               prog,
    input  logic [1:0]         sel_campo,
    input  logic               inc,
    input  logic               dec,
    input  logic               load,
    input  logic [CAMPO_W-1:0] dato_load,
    output logic [CAMPO_W-1:0] seg,
    output logic [CAMPO_W-1:0] min,
    output logic [CAMPO_W-1:0] hora,
    output logic               tick_seg,
    output logic               carry_dia,
    output logic               error_load
);

    estado_e            estado, estado_sig;
    sel_campo_e         sel;
    logic               tick;
    logic               err_sig, carry_sig;
    logic [CAMPO_W-1:0] seg_sig, min_sig, hora_sig;
    logic [CAMPO_W-1:0] campo, maximo, nuevo;

    assign sel = sel_campo_e'(sel_campo);

    divisor_tick #(.PRESCALE(PRESCALE)) u_divisor (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (estado == PROGRAMA),
        .tick    (tick)
    );

    always_comb begin
        estado_sig = prog ? PROGRAMA : CUENTA;
        carry_sig  = tick && (seg == MAX_SEG) && (min == MAX_MIN) && (hora == MAX_HORA);
        seg_sig    = seg;
        min_sig    = min;
        hora_sig   = hora;
        err_sig    = 1'b0;
        maximo     = max_campo(sel);
        case (sel)
            SEL_SEG:  campo = seg;
            SEL_MIN:  campo = min;
            SEL_HORA: campo = hora;
            default:  campo = '0;
        endcase
        nuevo = campo;

        // tick can only fire in CUENTA because the prescaler is cleared in PROGRAMA
        if (tick) begin
            if (seg == MAX_SEG) begin
                seg_sig = '0;
                if (min == MAX_MIN) begin
                    min_sig  = '0;
                    hora_sig = (hora == MAX_HORA) ? '0 : hora + 1'b1;
                end else begin
                    min_sig = min + 1'b1;
                end
            end else begin
                seg_sig = seg + 1'b1;
            end
        end else if (estado == PROGRAMA && sel != SEL_NINGUNO) begin
            if (load) begin
                if (dato_load <= maximo) nuevo = dato_load;
                else                     err_sig = 1'b1;
            end else if (inc && !dec) begin
                nuevo = (campo == maximo) ? '0 : campo + 1'b1;
            end else if (dec && !inc) begin
                nuevo = (campo == '0) ? maximo : campo - 1'b1;
            end
            case (sel)
                SEL_SEG:  seg_sig  = nuevo;
                SEL_MIN:  min_sig  = nuevo;
                SEL_HORA: hora_sig = nuevo;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado     <= CUENTA;
            seg        <= '0;
            min        <= '0;
            hora       <= '0;
            tick_seg   <= 1'b0;
            carry_dia  <= 1'b0;
            error_load <= 1'b0;
        end else begin
            estado     <= estado_sig;
            seg        <= seg_sig;
            min        <= min_sig;
            hora       <= hora_sig;
            tick_seg   <= tick;
            carry_dia  <= carry_sig;
            error_load <= err_sig;
        end
    end

endmodule

// File: tb/tb_contador_hora.sv
// Randomized and directed bench for contador_hora (PRESCALE=4) against a
// seconds-of-day reference model.
module tb_contador_hora;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset_n, en, prog, inc, dec, load;
    logic [1:0] sel_campo;
    logic [6:0] dato_load;
    logic [6:0] seg, min, hora;
    logic       tick_seg, carry_dia, error_load;

    int n_cmp = 0;
    int n_err = 0;
    int n_tick, n_carry;

    // reference model: time kept as seconds since midnight
    int m_t, m_pc, m_st, m_tk, m_cd, m_el;

    contador_hora #(.PRESCALE(P)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .prog       (prog),
        .sel_campo  (sel_campo),
        .inc        (inc),
        .dec        (dec),
        .load       (load),
        .dato_load  (dato_load),
        .seg        (seg),
        .min        (min),
        .hora       (hora),
        .tick_seg   (tick_seg),
        .carry_dia  (carry_dia),
        .error_load (error_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int f, mx, s, m, h;
        if (!reset_n) begin
            m_t = 0; m_pc = 0; m_st = 0; m_tk = 0; m_cd = 0; m_el = 0;
            return;
        end
        m_tk = 0; m_cd = 0; m_el = 0;
        if (m_st == 0) begin
            if (en) begin
                if (m_pc == P - 1) begin
                    m_pc = 0;
                    m_tk = 1;
                    if (m_t == 86399) m_cd = 1;
                    m_t = (m_t + 1) % 86400;
                end else begin
                    m_pc++;
                end
            end
        end else begin
            m_pc = 0;
            if (sel_campo != 2'b11) begin
                s = m_t % 60; m = (m_t / 60) % 60; h = m_t / 3600;
                f  = (sel_campo == 2'b00) ? s : (sel_campo == 2'b01) ? m : h;
                mx = (sel_campo == 2'b10) ? 23 : 59;
                if (load) begin
                    if (int'(dato_load) <= mx) f = dato_load;
                    else m_el = 1;
                end else if (inc && !dec) begin
                    f = (f + 1) % (mx + 1);
                end else if (dec && !inc) begin
                    f = (f + mx) % (mx + 1);
                end
                if (sel_campo == 2'b00) s = f;
                else if (sel_campo == 2'b01) m = f;
                else h = f;
                m_t = h * 3600 + m * 60 + s;
            end
        end
        m_st = prog ? 1 : 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
        chk("seg", seg, m_t % 60);
        chk("min", min, (m_t / 60) % 60);
        chk("hora", hora, m_t / 3600);
        chk("tick_seg", tick_seg, m_tk);
        chk("carry_dia", carry_dia, m_cd);
        chk("error_load", error_load, m_el);
        if (tick_seg) n_tick++;
        if (carry_dia) n_carry++;
    endtask

    task automatic idle_strobes();
        inc = 1'b0; dec = 1'b0; load = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] s, input int v);
        sel_campo = s; dato_load = 7'(v); load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; prog = 1'b0; sel_campo = 2'b11;
        dato_load = '0;
        idle_strobes();
        m_t = 0; m_pc = 0; m_st = 0; m_tk = 0; m_cd = 0; m_el = 0;

        // reset state
        cyc();
        cyc();
        chk("rst_time", {seg, min, hora}, 0);
        chk("rst_pulses", {tick_seg, carry_dia, error_load}, 0);

        // free run for one minute
        reset_n = 1'b1; en = 1'b1;
        n_tick = 0;
        for (int i = 0; i < 240; i++) cyc();
        chk("min_ticks", n_tick, 60);
        chk("min_seg", seg, 0);
        chk("min_min", min, 1);

        // en low freezes, strobes in CUENTA ignored
        en = 1'b0; sel_campo = 2'b00; inc = 1'b1; load = 1'b1; dato_load = 7'd30;
        for (int i = 0; i < 6; i++) cyc();
        idle_strobes();
        chk("hold_seg", seg, 0);
        en = 1'b1;

        // preset 23:59:58 and roll over midnight
        prog = 1'b1;
        cyc();
        do_load(2'b00, 58);
        do_load(2'b01, 59);
        do_load(2'b10, 23);
        chk("preset_h", hora, 23);
        prog = 1'b0;
        cyc();
        n_tick = 0; n_carry = 0;
        for (int i = 0; i < 4; i++) cyc();
        chk("pre_mid_seg", seg, 59);
        chk("pre_mid_tick", n_tick, 1);
        for (int i = 0; i < 4; i++) cyc();
        chk("mid_time", {hora, min, seg}, 0);
        chk("mid_carry_with_tick", {carry_dia, tick_seg}, 3);
        chk("mid_carry_cnt", n_carry, 1);

        // dec/inc wrap on seconds without carry
        prog = 1'b1;
        cyc();
        do_load(2'b00, 0);
        sel_campo = 2'b00; dec = 1'b1;
        cyc();
        dec = 1'b0;
        chk("dec_wrap_seg", seg, 59);
        chk("dec_wrap_min", min, 0);
        inc = 1'b1;
        cyc();
        inc = 1'b0;
        chk("inc_wrap_seg", seg, 0);
        chk("inc_wrap_min", min, 0);

        // rejected and accepted hour load
        do_load(2'b10, 24);
        chk("bad_load_h", hora, 0);
        chk("bad_load_err", error_load, 1);
        do_load(2'b10, 23);
        chk("good_load_h", hora, 23);
        chk("good_load_err", error_load, 0);

        // inc+dec cancels, load wins over inc
        sel_campo = 2'b01; inc = 1'b1; dec = 1'b1;
        cyc();
        chk("incdec_min", min, 0);
        dec = 1'b0; load = 1'b1; dato_load = 7'd10;
        cyc();
        idle_strobes();
        chk("load_inc_min", min, 10);

        // sel=11 ignores everything, including bad load
        sel_campo = 2'b11; load = 1'b1; dato_load = 7'd99;
        cyc();
        chk("none_err", error_load, 0);
        inc = 1'b1; load = 1'b0;
        cyc();
        idle_strobes();
        chk("none_min", min, 10);

        // reset during programming with pending load
        sel_campo = 2'b00; load = 1'b1; dato_load = 7'd5; reset_n = 1'b0;
        cyc();
        chk("rst_prog_time", {seg, min, hora}, 0);
        chk("rst_prog_err", error_load, 0);
        idle_strobes(); reset_n = 1'b1; prog = 1'b0;
        n_tick = 0;
        for (int i = 0; i < P; i++) cyc();
        chk("rst_first_tick", n_tick, 1);
        chk("rst_first_seg", seg, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n   = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 99) < 4) prog = ~prog;
            en        = ($urandom_range(0, 9) != 0);
            sel_campo = 2'($urandom_range(0, 3));
            inc       = ($urandom_range(0, 6) == 0);
            dec       = ($urandom_range(0, 6) == 0);
            load      = ($urandom_range(0, 7) == 0);
            dato_load = 7'($urandom_range(0, 70));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
